width_conv_queue: RTL and testbench
===================================

# width_conv_queue

Parametrised down-converting queue: accepts wide words of RATIO lanes on the write side and delivers them one OUT_WIDTH lane per read, least-significant lane first. It is the successor to the fixed 4-buffer feed-forward queue. It adds a generic width ratio and depth, per-word partial-lane counts, a programmable almost-full margin, an occupancy output, a synchronous clear and a sticky overflow flag. It sits between a wide producer (DMA/bus side) and a narrow consumer pipeline.

## Interface
- OUT_WIDTH, 32, read lane width in bits
- RATIO, 4, lanes per write word; power of 2, ≥1
- IN_WIDTH, OUT_WIDTH*RATIO, write word width (derived, do not override)
- DEPTH_LOG2, 4, log2 of stored write words; DEPTH = 2**DEPTH_LOG2
- AF_MARGIN, 2, almost_full asserts when level ≥ DEPTH−AF_MARGIN; range 1..DEPTH
- LANE_W, max(1,log2(RATIO)), width of lane-count field (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all contents
- write_en  in  1  write request
- data_in  in  IN_WIDTH  lane k = data_in[k*OUT_WIDTH +: OUT_WIDTH]
- in_lanes  in  LANE_W  valid lanes in data_in minus one (RATIO−1 = full word)
- waitrequest  out  1  identical to full
- read_en  in  1  request one lane
- data_out  out  OUT_WIDTH  registered lane
- data_valid  out  1  data_out carries a newly popped lane this cycle
- full  out  1  level == DEPTH
- almost_full  out  1  level ≥ DEPTH−AF_MARGIN
- empty  out  1  level == 0
- level  out  DEPTH_LOG2+1  stored words, including a partially consumed head
- overflow  out  1  sticky: write_en seen while full

## Operation
- Storage: DEPTH entries of {data, lane count}, with write pointer, read pointer and a LANE_W-bit lane index into the head entry.
- Write is accepted iff write_en && !full, using the registered full. A write while full is dropped and sets overflow. No same-cycle bypass when full, even if the head pops that cycle.
- Read: read_en && !empty pops lane[lane_idx] of the head entry.
  - If lane_idx == head in_lanes: head retires (read pointer+1, lane_idx←0).
  - Otherwise lane_idx+1.
- read_en while empty: no effect, data_valid stays 0.
- Lanes above in_lanes are never output. RATIO=1: every read retires an entry.
- Simultaneous accepted write and retire: level unchanged.
- Pointers wrap modulo DEPTH. level is a separate counter, 0..DEPTH.
- clr, when high, takes priority over write and read:
  - pointers, lane_idx and level go to 0; data_valid goes to 0 next cycle.
  - overflow is cleared; data_out is held.
- Reset values: data_out 0, data_valid 0, empty 1, full 0, waitrequest 0, almost_full 0, level 0, overflow 0, lane_idx 0, pointers 0.
- Asserting rst mid-transfer discards all contents immediately (asynchronous).

## Timing
- Write accepted at edge N: level/empty/full/almost_full update after edge N. The word is poppable by read_en in cycle N+1.
- Read_en high in cycle M with !empty: data_out/data_valid valid after edge M (one-cycle latency). data_valid is a single-cycle pulse per lane.
- Continuous read_en gives one lane per cycle, back to back, across entry boundaries with no bubble.
- level/flags reflect a retire after the same edge that pops the last lane.
- Status outputs are registered or decoded from registered level only, with no combinational path from write_en/read_en.

## Test plan
- Reset, then 4 full words (in_lanes=3) with lanes = 0..15, then 16 read_en cycles -> data_out 0,1,…,15 in order. data_valid high 16 cycles. empty after the last lane, level back to 0.
- Write one word with in_lanes=1 and lanes {A,B,C,D}, read 3 times -> A, B output, third read_en gives data_valid 0. empty=1 after the second pop.
- DEPTH=16, AF_MARGIN=2, write 17 words without reads:
  - almost_full rises after the 14th write; full/waitrequest after the 16th.
  - The 17th write is dropped and overflow=1.
  - Reading all 64 lanes returns only the first 16 words.
- Full queue, write_en and read_en held together for 4 cycles -> no write is accepted until the head retires (4th read). Then writes resume, and level never exceeds 16.
- 1000 words of random data with random in_lanes and random write_en/read_en duty -> output stream equals the scoreboard lane sequence, level never wraps, and the pointers wrap several times.
- clr asserted mid-stream with 5 words queued and lane_idx=2 -> next cycle empty=1, level=0, overflow=0. A following write/read returns only the new data. An async rst pulse mid-read gives the same result, with all outputs at their reset values.

Source files
------------

// File: rtl/width_conv_queue_if.sv
// Write-side / read-side bundle of the down-converting queue.
// master = producer/consumer side, slave = the queue itself.
interface width_conv_queue_if #(
  parameter int OUT_WIDTH  = 32,
  parameter int RATIO      = 4,
  parameter int DEPTH_LOG2 = 4
);
  localparam int IN_WIDTH = OUT_WIDTH * RATIO;
  localparam int LANE_W   = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic                  clr;
  logic                  write_en;
  logic [IN_WIDTH-1:0]   data_in;
  logic [LANE_W-1:0]     in_lanes;
  logic                  waitrequest;
  logic                  read_en;
  logic [OUT_WIDTH-1:0]  data_out;
  logic                  data_valid;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;

  modport master (
    output clr, write_en, data_in, in_lanes, read_en,
    input  waitrequest, data_out, data_valid, full, almost_full, empty, level, overflow
  );

  modport slave (
    input  clr, write_en, data_in, in_lanes, read_en,
    output waitrequest, data_out, data_valid, full, almost_full, empty, level, overflow
  );
endinterface

// File: rtl/width_conv_queue.sv
// Down-converting queue: stores RATIO-lane words, pops one lane per read (LSB lane first),
// one-cycle read latency; waitrequest (== full) backpressures the writer, overflow is sticky.
module width_conv_queue #(
  parameter int OUT_WIDTH  = 32,
  parameter int RATIO      = 4,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_MARGIN  = 2,
  localparam int IN_WIDTH  = OUT_WIDTH * RATIO,
  localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic               clk,
  input  logic               rst,
  width_conv_queue_if.slave  q
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_AF   = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);

  logic [IN_WIDTH-1:0]   mem_dat_q [DEPTH];
  logic [LANE_W-1:0]     mem_ln_q  [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0]     lane_idx_q, lane_idx_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [OUT_WIDTH-1:0]  data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overflow_q, overflow_d;

  logic                  full, empty, wr_acc, rd_acc, retire;
  logic [IN_WIDTH-1:0]   head_dat;
  logic [LANE_W-1:0]     head_ln;
  logic [OUT_WIDTH-1:0]  head_lane;

  // Flags decode registered level only, so nothing is combinational from write_en/read_en.
  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign wr_acc   = q.write_en && !full;
  assign rd_acc   = q.read_en && !empty;
  assign head_dat = mem_dat_q[rd_ptr_q];
  assign head_ln  = (RATIO == 1) ? '0 : mem_ln_q[rd_ptr_q];
  assign retire   = rd_acc && (lane_idx_q == head_ln);

  always_comb begin
    head_lane = head_dat[OUT_WIDTH-1:0];
    for (int k = 1; k < RATIO; k++) begin
      if (lane_idx_q == LANE_W'(k)) head_lane = head_dat[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lane_idx_d   = lane_idx_q;
    level_d      = level_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q | (q.write_en && full);
    if (q.clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      lane_idx_d = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        data_out_d   = head_lane;
        data_valid_d = 1'b1;
        if (retire) begin
          rd_ptr_d   = rd_ptr_q + 1'b1;
          lane_idx_d = '0;
        end else begin
          lane_idx_d = lane_idx_q + 1'b1;
        end
      end
      case ({wr_acc, retire})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lane_idx_q   <= '0;
      level_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lane_idx_q   <= lane_idx_d;
      level_q      <= level_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: level/pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_acc && !q.clr) begin
      mem_dat_q[wr_ptr_q] <= q.data_in;
      mem_ln_q[wr_ptr_q]  <= q.in_lanes;
    end
  end

  assign q.data_out    = data_out_q;
  assign q.data_valid  = data_valid_q;
  assign q.full        = full;
  assign q.waitrequest = full;
  assign q.almost_full = (level_q >= LVL_AF);
  assign q.empty       = empty;
  assign q.level       = level_q;
  assign q.overflow    = overflow_q;
endmodule

// File: tb/tb_width_conv_queue.sv
// Directed and randomised checks of width_conv_queue (OUT_WIDTH=32, RATIO=4, DEPTH=16, AF_MARGIN=2).
module tb_width_conv_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  width_conv_queue_if #(.OUT_WIDTH(32), .RATIO(4), .DEPTH_LOG2(4)) bus ();
  width_conv_queue #(.OUT_WIDTH(32), .RATIO(4), .DEPTH_LOG2(4), .AF_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .q(bus)
  );

  // Reference model: queue of words, head lane index, expected output.
  logic [127:0] mq_dat[$];
  logic [1:0]   mq_ln[$];
  int           m_idx = 0;
  int           m_lvl = 0;
  bit           exp_vld = 1'b0;
  logic [31:0]  exp_dout = '0;

  function automatic logic [127:0] mkw(input int base);
    return {32'(base + 3), 32'(base + 2), 32'(base + 1), 32'(base)};
  endfunction

  task automatic model_reset();
    mq_dat.delete(); mq_ln.delete();
    m_idx = 0; m_lvl = 0; exp_vld = 1'b0; exp_dout = '0;
  endtask

  task automatic model_step(input bit we, input logic [127:0] d, input logic [1:0] ln,
                            input bit re, input bit c);
    logic [127:0] hw;
    bit           was_full;
    exp_vld = 1'b0;
    if (c) begin
      mq_dat.delete(); mq_ln.delete(); m_idx = 0; m_lvl = 0;
      return;
    end
    was_full = (m_lvl == 16);
    if (re && m_lvl != 0) begin
      hw       = mq_dat[0];
      exp_dout = hw[m_idx*32 +: 32];
      exp_vld  = 1'b1;
      if (m_idx == int'(mq_ln[0])) begin
        void'(mq_dat.pop_front()); void'(mq_ln.pop_front()); m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    if (we && !was_full) begin
      mq_dat.push_back(d); mq_ln.push_back(ln);
    end
    m_lvl = mq_dat.size();
  endtask

  // One clock: drive inputs, advance the model, land 1ns after the edge.
  task automatic cyc(input bit we, input logic [127:0] d, input logic [1:0] ln,
                     input bit re, input bit c);
    bus.write_en = we; bus.data_in = d; bus.in_lanes = ln; bus.read_en = re; bus.clr = c;
    model_step(we, d, ln, re, c);
    @(posedge clk); #1;
    bus.write_en = 1'b0; bus.read_en = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.data_out !== 32'd0) begin errors++; $display("FAIL rst_data_out got %h exp 0", bus.data_out); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid got %b exp 0", bus.data_valid); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", bus.empty); end
    checks++; if ({bus.full, bus.waitrequest, bus.almost_full, bus.overflow} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got %b exp 0000", {bus.full, bus.waitrequest, bus.almost_full, bus.overflow}); end
    checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", bus.level); end
    rst = 1'b0;
  endtask

  task automatic test_in_order();
    for (int w = 0; w < 4; w++) cyc(1'b1, mkw(4*w), 2'd3, 1'b0, 1'b0);
    checks++; if (bus.level !== 5'd4) begin errors++; $display("FAIL order_level got %0d exp 4", bus.level); end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
      checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 32'(i)) begin
        errors++; $display("FAIL order_lane[%0d] got vld=%b %0d exp vld=1 %0d", i, bus.data_valid, bus.data_out, i); end
    end
    checks++; if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      errors++; $display("FAIL order_drained got empty=%b level=%0d exp 1 0", bus.empty, bus.level); end
    cyc(1'b0, '0, 2'd0, 1'b0, 1'b0);
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL order_pulse got %b exp 0", bus.data_valid); end
  endtask

  task automatic test_partial();
    cyc(1'b1, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 2'd1, 1'b0, 1'b0);
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 32'hAAAA_0001 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL partial_a got vld=%b %h empty=%b exp 1 aaaa0001 0", bus.data_valid, bus.data_out, bus.empty); end
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 32'hBBBB_0002 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL partial_b got vld=%b %h empty=%b exp 1 bbbb0002 1", bus.data_valid, bus.data_out, bus.empty); end
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL partial_empty_read got %b exp 0", bus.data_valid); end
  endtask

  task automatic test_full_overflow();
    for (int w = 0; w < 17; w++) begin
      cyc(1'b1, (w < 16) ? mkw(3000 + 4*w) : {4{32'd9999}}, 2'd3, 1'b0, 1'b0);
      checks++; if (bus.almost_full !== (w + 1 >= 14)) begin
        errors++; $display("FAIL af_after_write[%0d] got %b exp %b", w + 1, bus.almost_full, (w + 1 >= 14)); end
      checks++; if (bus.full !== (w + 1 >= 16) || bus.waitrequest !== (w + 1 >= 16)) begin
        errors++; $display("FAIL full_after_write[%0d] got %b/%b exp %b", w + 1, bus.full, bus.waitrequest, (w + 1 >= 16)); end
      checks++; if (bus.overflow !== (w == 16)) begin
        errors++; $display("FAIL ovf_after_write[%0d] got %b exp %b", w + 1, bus.overflow, (w == 16)); end
    end
    checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", bus.level); end
    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
      checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 32'(3000 + i)) begin
        errors++; $display("FAIL full_drain[%0d] got vld=%b %0d exp 1 %0d", i, bus.data_valid, bus.data_out, 3000 + i); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] lv_exp [5] = '{5'd16, 5'd16, 5'd16, 5'd15, 5'd16};
    for (int w = 0; w < 16; w++) cyc(1'b1, mkw(1000 + 4*w), 2'd3, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, mkw(2000), 2'd3, 1'b1, 1'b0);
      checks++; if (bus.level !== lv_exp[c] || bus.data_out !== 32'(1000 + c)) begin
        errors++; $display("FAIL b2b[%0d] got level=%0d %0d exp %0d %0d", c, bus.level, bus.data_out, lv_exp[c], 1000 + c); end
    end
    for (int i = 0; i < 63; i++) begin
      int ev;
      ev = (i < 59) ? 1005 + i : 2000 + (i - 59);
      cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
      checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 32'(ev) || bus.level > 5'd16) begin
        errors++; $display("FAIL b2b_drain[%0d] got vld=%b %0d lvl=%0d exp 1 %0d", i, bus.data_valid, bus.data_out, bus.level, ev); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_random();
    int acc = 0;
    int n = 0;
    bit we, re;
    while (acc < 1000 && n < 20000) begin
      we = ($urandom_range(0, 99) < ((n % 400 < 200) ? 80 : 40));
      re = ($urandom_range(0, 99) < ((n % 400 < 200) ? 40 : 90));
      if (we && m_lvl != 16) acc++;
      cyc(we, {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)), re, 1'b0);
      n++;
      checks++; if (bus.data_valid !== exp_vld || (exp_vld && bus.data_out !== exp_dout)) begin
        errors++; $display("FAIL rand_out[%0d] got vld=%b %h exp vld=%b %h", n, bus.data_valid, bus.data_out, exp_vld, exp_dout); end
      checks++; if (bus.level !== 5'(m_lvl) || bus.level > 5'd16) begin
        errors++; $display("FAIL rand_level[%0d] got %0d exp %0d", n, bus.level, m_lvl); end
    end
    checks++; if (acc < 1000) begin errors++; $display("FAIL rand_timeout got %0d words exp 1000", acc); end
    n = 0;
    while (m_lvl > 0 && n < 200) begin
      cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
      n++;
      checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== exp_dout) begin
        errors++; $display("FAIL rand_drain[%0d] got vld=%b %h exp 1 %h", n, bus.data_valid, bus.data_out, exp_dout); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rand_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_clr_rst();
    for (int w = 0; w < 5; w++) cyc(1'b1, mkw(5000 + 4*w), 2'd3, 1'b0, 1'b0);
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.overflow !== 1'b1 || bus.level !== 5'd5) begin
      errors++; $display("FAIL clr_pre got ovf=%b level=%0d exp 1 5", bus.overflow, bus.level); end
    cyc(1'b1, mkw(8000), 2'd3, 1'b1, 1'b1);
    checks++; if (bus.empty !== 1'b1 || bus.level !== 5'd0 || bus.overflow !== 1'b0 || bus.data_valid !== 1'b0) begin
      errors++; $display("FAIL clr_state got empty=%b lvl=%0d ovf=%b vld=%b exp 1 0 0 0", bus.empty, bus.level, bus.overflow, bus.data_valid); end
    checks++; if (bus.data_out !== 32'd5001) begin errors++; $display("FAIL clr_hold got %0d exp 5001", bus.data_out); end
    cyc(1'b1, mkw(6000), 2'd3, 1'b0, 1'b0);
    cyc(1'b1, mkw(6100), 2'd3, 1'b1, 1'b0);
    checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 32'd6000 || bus.level !== 5'd2) begin
      errors++; $display("FAIL clr_new got vld=%b %0d lvl=%0d exp 1 6000 2", bus.data_valid, bus.data_out, bus.level); end
    bus.read_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.data_out !== 32'd0 || bus.data_valid !== 1'b0 || bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      errors++; $display("FAIL arst_out got %0d vld=%b empty=%b lvl=%0d exp 0 0 1 0", bus.data_out, bus.data_valid, bus.empty, bus.level); end
    checks++; if ({bus.full, bus.waitrequest, bus.almost_full, bus.overflow} !== 4'b0000) begin
      errors++; $display("FAIL arst_flags got %b exp 0000", {bus.full, bus.waitrequest, bus.almost_full, bus.overflow}); end
    @(posedge clk); #1;
    bus.read_en = 1'b0;
    rst = 1'b0;
    model_reset();
    cyc(1'b1, mkw(7000), 2'd0, 1'b0, 1'b0);
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 32'd7000 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL arst_new got vld=%b %0d empty=%b exp 1 7000 1", bus.data_valid, bus.data_out, bus.empty); end
  endtask

  initial begin
    bus.clr = 1'b0; bus.write_en = 1'b0; bus.read_en = 1'b0;
    bus.data_in = '0; bus.in_lanes = '0;
    test_reset();
    test_in_order();
    test_partial();
    test_full_overflow();
    test_back_to_back();
    test_random();
    test_clr_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
